// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants, pointer type and gray-code helpers for async_fifo_gray
`timescale 1ns/1ps

package async_fifo_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Helpers work on a fixed wide vector; callers zero-extend narrower
    // pointers and truncate the result, which is exact for gray coding.
    localparam int GRAY_MAX_W = 32;

    localparam int DEF_ADDR_W = 6;
    typedef logic [DEF_ADDR_W:0] fifo_ptr_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all gray bits at and above it; zero
    // upper bits leave the result unchanged, so no width argument is needed.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchroniser for a gray-coded pointer, async clear
//   clk    destination-domain clock
//   rst_n  asynchronous active-low clear of all stages
//   d      gray value from the source domain (registered there)
//   q      value after STAGES destination flops
`timescale 1ns/1ps

module gray_sync
    import async_fifo_pkg::*;
#(
    parameter int W      = 7,
    parameter int STAGES = MIN_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// rtl/async_fifo_gray.sv - dual-clock FIFO with gray-coded pointer crossing
//   Optional build macro: ASYNC_FIFO_FWFT_EN (first-word-fall-through read port).
//   wr_clk domain: wr_en, wr_data, full, almost_full, wr_level, overflow
//   rd_clk domain: rd_en, rd_data, rd_valid, empty, almost_empty, rd_level, underflow
//   reset_n: asynchronous active-low, deassertion synchronised into each domain
`timescale 1ns/1ps

module async_fifo_gray
    import async_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int AF_TH       = 56,
    parameter int AE_TH       = 8
) (
    input  logic              rd_clk,
    input  logic              wr_clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_TH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_TH);

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
        $error("async_fifo_gray: SYNC_STAGES out of range");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset synchronisers: assert immediately, release on the local clock.
    logic [1:0] wr_rst_q;
    logic [1:0] rd_rst_q;
    logic       wr_rst_n;
    logic       rd_rst_n;

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) wr_rst_q <= 2'b00;
        else          wr_rst_q <= {wr_rst_q[0], 1'b1};
    end

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) rd_rst_q <= 2'b00;
        else          rd_rst_q <= {rd_rst_q[0], 1'b1};
    end

    assign wr_rst_n = wr_rst_q[1];
    assign rd_rst_n = rd_rst_q[1];

    // Write domain
    logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PTR_W-1:0] rgray_sync, rsync_bin, wr_level_next, full_match;
    logic             wr_fire;

    always_comb begin
        wr_fire       = wr_en && !full;
        wbin_next     = wbin + PTR_W'(wr_fire);
        wgray_next    = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_next)));
        rsync_bin     = PTR_W'(gray2bin(GRAY_MAX_W'(rgray_sync)));
        wr_level_next = wbin_next - rsync_bin;
        // Full when the writer is exactly one lap ahead: top two gray bits inverted.
        full_match    = {~rgray_sync[PTR_W-1:PTR_W-2], rgray_sync[PTR_W-3:0]};
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            full        <= (wgray_next == full_match);
            almost_full <= (wr_level_next >= AF_LVL);
            wr_level    <= wr_level_next;
            overflow    <= wr_en && full;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_fire) mem[wbin[ADDR_W-1:0]] <= wr_data;
    end

    // Read domain
    logic [PTR_W-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [PTR_W-1:0] wgray_sync, wsync_bin, rd_level_next;
    logic             arr_empty;
    logic             rd_fire;
    logic             rd_valid_next;
    logic             underflow_next;

    always_comb begin
`ifdef ASYNC_FIFO_FWFT_EN
        // The output register refills whenever it is empty or being popped.
        rd_fire        = !arr_empty && (!rd_valid || rd_en);
        rd_valid_next  = rd_fire || (rd_valid && !rd_en);
        underflow_next = rd_en && !rd_valid;
`else
        rd_fire        = rd_en && !arr_empty;
        rd_valid_next  = rd_fire;
        underflow_next = rd_en && arr_empty;
`endif
        rbin_next  = rbin + PTR_W'(rd_fire);
        rgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_next)));
        wsync_bin  = PTR_W'(gray2bin(GRAY_MAX_W'(wgray_sync)));
`ifdef ASYNC_FIFO_FWFT_EN
        rd_level_next = wsync_bin - rbin_next + PTR_W'(rd_valid_next);
`else
        rd_level_next = wsync_bin - rbin_next;
`endif
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rbin         <= '0;
            rgray        <= '0;
            arr_empty    <= 1'b1;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            arr_empty    <= (rgray_next == wgray_sync);
            if (rd_fire) rd_data <= mem[rbin[ADDR_W-1:0]];
            rd_valid     <= rd_valid_next;
            almost_empty <= (rd_level_next <= AE_LVL);
            rd_level     <= rd_level_next;
            underflow    <= underflow_next;
        end
    end

`ifdef ASYNC_FIFO_FWFT_EN
    assign empty = !rd_valid;
`else
    assign empty = arr_empty;
`endif

    gray_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .d     (wgray),
        .q     (wgray_sync)
    );

    gray_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .d     (rgray),
        .q     (rgray_sync)
    );

endmodule

// File: tb/tb_async_fifo_gray.sv
// tb/tb_async_fifo_gray.sv - self-checking bench for async_fifo_gray
`timescale 1ns/1ps

module tb_async_fifo_gray;
    import async_fifo_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = DEF_ADDR_W;
    localparam int SYNC   = 2;
    localparam int N5     = 10000;

    logic              rd_clk = 1'b0;
    logic              wr_clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full, almost_full, overflow;
    logic [ADDR_W:0]   wr_level;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, empty, almost_empty, underflow;
    fifo_ptr_t         rd_level;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int   n_writes;
        logic exp_full;
        logic exp_af;
        int   exp_level;
    } fill_vec_t;

    fill_vec_t fill_tab[6];

    always #5    wr_clk = ~wr_clk;
    always #13.5 rd_clk = ~rd_clk;

    async_fifo_gray #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AF_TH(56), .AE_TH(8)
    ) dut (
        .rd_clk       (rd_clk),
        .wr_clk       (wr_clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wr_cycle(input logic en, input logic [DATA_W-1:0] d);
        wr_en   = en;
        wr_data = d;
        @(posedge wr_clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic rd_cycle(input logic en);
        rd_en = en;
        @(posedge rd_clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic wait_not_empty(output int n);
        n = 0;
        while (empty && n < 20) begin
            @(posedge rd_clk); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        #40;
        reset_n = 1'b1;
        repeat (5) @(posedge rd_clk);
        @(posedge wr_clk); #1;
    endtask

    int written;
    int lat;
    int nr, nw, t5_err, guard;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] exp_w;
    logic fire;

    initial begin
        fill_tab[0] = '{1,  1'b0, 1'b0, 1};
        fill_tab[1] = '{55, 1'b0, 1'b0, 55};
        fill_tab[2] = '{56, 1'b0, 1'b1, 56};
        fill_tab[3] = '{57, 1'b0, 1'b1, 57};
        fill_tab[4] = '{63, 1'b0, 1'b1, 63};
        fill_tab[5] = '{64, 1'b1, 1'b1, 64};

        wr_data = '0;
        do_reset();

        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_wr_level", wr_level, 0);
        chk("rst_rd_level", rd_level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flow_strobes", {overflow, underflow}, 0);

        // Test 1: fill with 0x00..0x3F, checkpoints from the table
        written = 0;
        for (int v = 0; v < 6; v++) begin
            while (written < fill_tab[v].n_writes) begin
                wr_cycle(1'b1, 8'(written));
                written++;
            end
            chk($sformatf("fill%0d_full", fill_tab[v].n_writes), full, fill_tab[v].exp_full);
            chk($sformatf("fill%0d_af", fill_tab[v].n_writes), almost_full, fill_tab[v].exp_af);
            chk($sformatf("fill%0d_level", fill_tab[v].n_writes), wr_level, fill_tab[v].exp_level);
        end
        chk("fill_no_overflow", overflow, 0);

        // Test 3: writes while full are dropped
        for (int i = 0; i < 3; i++) begin
            wr_cycle(1'b1, 8'hEE);
            chk($sformatf("ovf%0d_pulse", i), overflow, 1);
            chk($sformatf("ovf%0d_level", i), wr_level, 64);
        end
        wr_cycle(1'b0, 8'h00);
        chk("ovf_cleared", overflow, 0);
        chk("ovf_still_full", full, 1);

        repeat (6) @(posedge rd_clk); #1;
        chk("full_rd_level", rd_level, 64);
        chk("full_rd_ae", almost_empty, 0);
        chk("full_rd_empty", empty, 0);

        for (int k = 1; k <= 64; k++) begin
`ifdef ASYNC_FIFO_FWFT_EN
            chk($sformatf("drain%0d", k), {rd_valid, rd_data}, {1'b1, 8'(k - 1)});
            rd_cycle(1'b1);
`else
            rd_cycle(1'b1);
            chk($sformatf("drain%0d", k), {rd_valid, rd_data}, {1'b1, 8'(k - 1)});
`endif
            if (k == 55) begin
                chk("drain55_level", rd_level, 9);
                chk("drain55_ae", almost_empty, 0);
            end
            if (k == 56) begin
                chk("drain56_level", rd_level, 8);
                chk("drain56_ae", almost_empty, 1);
            end
        end
        chk("drained_empty", empty, 1);
        chk("drained_rd_level", rd_level, 0);
        repeat (6) @(posedge wr_clk); #1;
        chk("drained_full", full, 0);
        chk("drained_wr_level", wr_level, 0);
        chk("drained_af", almost_full, 0);

        // Test 4: read on empty
        rd_cycle(1'b1);
        chk("udf_pulse", underflow, 1);
        chk("udf_rd_valid", rd_valid, 0);
        chk("udf_rd_data_held", rd_data, 8'h3F);
        chk("udf_rd_level", rd_level, 0);
        rd_cycle(1'b0);
        chk("udf_cleared", underflow, 0);

        // Test 2: single word latency
        @(posedge wr_clk); #1;
        wr_cycle(1'b1, 8'hA5);
        wait_not_empty(lat);
        chk("a5_empty_latency_ok", lat <= SYNC + 2, 1);
        chk("a5_rd_level", rd_level, 1);
`ifdef ASYNC_FIFO_FWFT_EN
        chk("a5_head_visible", {rd_valid, rd_data}, {1'b1, 8'hA5});
        rd_cycle(1'b1);
        chk("a5_popped_valid", rd_valid, 0);
`else
        rd_cycle(1'b1);
        chk("a5_read", {rd_valid, rd_data}, {1'b1, 8'hA5});
        rd_cycle(1'b0);
        chk("a5_valid_drop", rd_valid, 0);
`endif
        chk("a5_data_held", rd_data, 8'hA5);
        chk("a5_empty_after", empty, 1);

        // Test 5: concurrent random traffic
        nw = 0; nr = 0; t5_err = 0;
        fork
            begin
                guard = 0;
                @(posedge wr_clk); #1;
                while (nw < N5 && guard < 60000) begin
                    if (!full && $urandom_range(0, 1) == 1) begin
                        wr_en   = 1'b1;
                        wr_data = 8'($urandom);
                        sb.push_back(wr_data);
                        nw++;
                    end else begin
                        wr_en = 1'b0;
                    end
                    @(posedge wr_clk); #1;
                    guard++;
                end
                wr_en = 1'b0;
            end
            begin
                @(posedge rd_clk); #1;
                for (int g = 0; g < 25000 && nr < N5; g++) begin
`ifdef ASYNC_FIFO_FWFT_EN
                    fire = rd_valid && ($urandom_range(0, 7) != 0);
                    if (fire) begin
                        exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                        if (rd_data !== exp_w) t5_err++;
                        nr++;
                    end
                    rd_en = fire;
                    @(posedge rd_clk); #1;
`else
                    fire = !empty && ($urandom_range(0, 7) != 0);
                    rd_en = fire;
                    @(posedge rd_clk); #1;
                    if (fire) begin
                        exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                        if (!rd_valid || rd_data !== exp_w) t5_err++;
                        nr++;
                    end
`endif
                end
                rd_en = 1'b0;
            end
        join
        chk("t5_order_errors", t5_err, 0);
        chk("t5_words_written", nw, N5);
        chk("t5_words_read", nr, N5);
        chk("t5_scoreboard_left", sb.size(), 0);

        // Test 6: reset in the middle of a burst at level 20
        repeat (4) @(posedge rd_clk);
        @(posedge wr_clk); #1;
        for (int i = 0; i < 20; i++) wr_cycle(1'b1, 8'(8'h10 + i));
        repeat (8) @(posedge rd_clk); #1;
        chk("pre_rst_rd_level", rd_level, 20);
        chk("pre_rst_wr_level", wr_level, 20);
        @(posedge wr_clk); #1;
        wr_en = 1'b1;
        wr_data = 8'h77;
        #3;
        reset_n = 1'b0;
        #30;
        wr_en = 1'b0;
        reset_n = 1'b1;
        repeat (5) @(posedge rd_clk);
        @(posedge wr_clk); #1;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_wr_level", wr_level, 0);
        chk("mid_rst_rd_level", rd_level, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        wr_cycle(1'b1, 8'h5C);
        wait_not_empty(lat);
        chk("post_rst_latency_ok", lat <= SYNC + 2, 1);
`ifdef ASYNC_FIFO_FWFT_EN
        chk("post_rst_word", {rd_valid, rd_data}, {1'b1, 8'h5C});
        rd_cycle(1'b1);
`else
        rd_cycle(1'b1);
        chk("post_rst_word", {rd_valid, rd_data}, {1'b1, 8'h5C});
`endif
        chk("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
